ram_access_responder: RTL and testbench

//  RAM-side responder for the address calculation line: consumes the shared 32-bit addr bus plus

---
 rtl/ram_access_responder_pkg.sv | 19 +
 rtl/ram_access_responder_rd_fifo.sv | 72 +++++++
 rtl/ram_access_responder.sv | 166 ++++++++++++++++
 tb/tb_ram_access_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_responder_pkg.sv
// Shared types and defaults for the RAM access responder: FSM states, arbiter grant tags and default widths.
package ram_access_responder_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_access_responder_rd_fifo.sv
// Read-data FIFO: synchronous push/pop/clear, occupancy count and a registered head word (0 when empty).
module ram_rd_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     cnt_d;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    valid      = (count != '0);
    do_pop     = pop && valid;
    do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    rd_ptr_nxt = rd_ptr + PW'(1);
    cnt_d      = count;
    if (do_push && !do_pop)
      cnt_d = count + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  // Head register tracks the word that will be at rd_ptr after this edge,
  // taking it straight from push_data when the pushed word becomes the only entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr_nxt;
      count <= cnt_d;
      if (cnt_d == '0)
        head <= '0;
      else if (do_push && ((count == '0) || ((count == CW'(1)) && do_pop)))
        head <= push_data;
      else if (do_pop)
        head <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/ram_access_responder.sv
// RAM-side responder: FSM, read/write round-robin arbiter, in-flight read tracking and registered RAM port.
// Optional address bounds checking is enabled with `define ADDR_BOUNDS_CHECK_EN.
module ram_access_responder
  import ram_access_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       addr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
`ifdef ADDR_BOUNDS_CHECK_EN
  input  logic [31:0]       base,
  input  logic [31:0]       limit,
  output logic              addr_err,
`endif
  output logic              read_pause,
  output logic              write_pause,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  grant_t            rr_last_q;
  logic              flush_cnt_q;
  logic              active;
  logic              rd_room;
  logic              rd_cand;
  logic              wr_cand;
  logic              gnt_rd;
  logic              gnt_wr;
  logic              in_bounds;
  logic              issue_rd;
  logic              issue_wr;
  logic              pend1_q, pend2_q;
  logic              pend1_drop_q, pend2_drop_q;
  logic [1:0]        inflight;
  logic [CW:0]       occupancy;
  logic [CW-1:0]     fifo_count;
  logic              fifo_clear;
  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable)      state_d = ST_ACTIVE;
      ST_ACTIVE: if (!enable)     state_d = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt_q) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase

    active    = (state_q == ST_ACTIVE);
    inflight  = {1'b0, pend1_q} + {1'b0, pend2_q};
    occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight);
    rd_room   = (occupancy < (CW+1)'(FIFO_DEPTH));

    // A read that cannot be taken for lack of room never blocks a pending write.
    rd_cand     = rd_req && active && rd_room;
    wr_cand     = wr_req && active;
    gnt_rd      = rd_cand && (!wr_cand || (rr_last_q == GNT_WR));
    gnt_wr      = wr_cand && !gnt_rd;
    read_pause  = !active || !rd_room || gnt_wr;
    write_pause = !active || gnt_rd;

    issue_rd   = gnt_rd && in_bounds;
    issue_wr   = gnt_wr && in_bounds;
    fifo_clear = !active;
    fifo_push  = active && pend2_q;
    fifo_wdata = pend2_drop_q ? '0 : ram_rdata;
    fifo_pop   = rd_valid && rd_ready;
  end

`ifdef ADDR_BOUNDS_CHECK_EN
  logic [32:0] bound_end;

  always_comb begin
    bound_end = {1'b0, base} + {1'b0, limit};
    in_bounds = (addr >= base) && ({1'b0, addr} < bound_end);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      addr_err <= 1'b0;
    else if (state_q == ST_IDLE)
      addr_err <= 1'b0;
    else if ((gnt_rd || gnt_wr) && !in_bounds)
      addr_err <= 1'b1;
  end
`else
  always_comb in_bounds = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= 1'b0;
      rr_last_q    <= GNT_WR;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      pend1_drop_q <= 1'b0;
      pend2_drop_q <= 1'b0;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == ST_FLUSH);
      if (gnt_rd)
        rr_last_q <= GNT_RD;
      else if (gnt_wr)
        rr_last_q <= GNT_WR;

      ram_cs <= issue_rd || issue_wr;
      ram_we <= issue_wr;
      if (issue_rd || issue_wr)
        ram_addr <= addr[ADDR_W-1:0];
      if (issue_wr)
        ram_wdata <= wr_data;

      // Dropped (out-of-bounds) reads travel the same pipe so FIFO order is kept.
      if (active) begin
        pend1_q      <= gnt_rd;
        pend1_drop_q <= gnt_rd && !in_bounds;
        pend2_q      <= pend1_q;
        pend2_drop_q <= pend1_drop_q;
      end else begin
        pend1_q      <= 1'b0;
        pend1_drop_q <= 1'b0;
        pend2_q      <= 1'b0;
        pend2_drop_q <= 1'b0;
      end
    end
  end

  ram_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (rd_data),
    .valid     (rd_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ram_access_responder.sv
// Scoreboard bench for ram_access_responder with a behavioural single-port synchronous RAM.
module tb_ram_access_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        read_pause;
  logic        write_pause;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
`ifdef ADDR_BOUNDS_CHECK_EN
  logic [31:0] base  = '0;
  logic [31:0] limit = 32'hFFFF_FFFF;
  logic        addr_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q   [$];
  int unsigned acc;

  always #5 clk = ~clk;

  ram_access_responder #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .addr        (addr),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
`ifdef ADDR_BOUNDS_CHECK_EN
    .base        (base),
    .limit       (limit),
    .addr_err    (addr_err),
`endif
    .read_pause  (read_pause),
    .write_pause (write_pause),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accepts and pops are observed mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid && rd_ready) begin
        check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
      end
      if (rd_req && wr_req) check("one_grant", 32'(!read_pause && !write_pause), 32'd0);
      if (rd_req && !read_pause) exp_q.push_back(ref_mem[addr[7:0]]);
      if (wr_req && !write_pause) ref_mem[addr[7:0]] = wr_data;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    rd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      nxt();
      n++;
    end
    nxt();
    nxt();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; addr = '0; rd_req = 1'b0; wr_req = 1'b0;
    wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    ram[8'h10]     = 32'h0000_CAFE;
    ref_mem[8'h10] = 32'h0000_CAFE;

    // Reset state
    smp();
    check("rst_rp", 32'(read_pause), 32'd1);
    check("rst_wp", 32'(write_pause), 32'd1);
    check("rst_cs", 32'(ram_cs), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", rd_data, 32'd0);
    nxt(); reset = 1'b0; enable = 1'b1;
    smp(); check("idle_pause", 32'(read_pause), 32'd1);
    nxt(); smp();
    check("act_rp", 32'(read_pause), 32'd0);
    check("act_wp", 32'(write_pause), 32'd0);

    // Single read, latency to RAM port and to rd_valid
    nxt(); rd_req = 1'b1; addr = 32'h10;
    smp(); check("t2_acc", 32'(read_pause), 32'd0);
    nxt(); rd_req = 1'b0;
    smp();
    check("t2_cs", 32'(ram_cs), 32'd1);
    check("t2_we", 32'(ram_we), 32'd0);
    check("t2_addr", ram_addr, 32'h10);
    nxt(); smp(); check("t2_early_valid", 32'(rd_valid), 32'd0);
    nxt(); smp();
    check("t2_valid", 32'(rd_valid), 32'd1);
    check("t2_data", rd_data, 32'h0000_CAFE);
    nxt(); rd_ready = 1'b1;
    drain();

    // Write then readback
    wr_req = 1'b1; addr = 32'h20; wr_data = 32'h1234;
    smp(); check("t3_acc", 32'(write_pause), 32'd0);
    nxt(); wr_req = 1'b0;
    smp();
    check("t3_cs", 32'(ram_cs), 32'd1);
    check("t3_we", 32'(ram_we), 32'd1);
    check("t3_addr", ram_addr, 32'h20);
    check("t3_wdata", ram_wdata, 32'h1234);
    nxt(); rd_req = 1'b1; addr = 32'h20;
    smp(); check("t3_rd_acc", 32'(read_pause), 32'd0);
    nxt(); rd_req = 1'b0;
    drain();

    // FIFO fill with no pops: exactly FIFO_DEPTH accepted, one more after a pop
    rd_ready = 1'b0; acc = 0;
    for (int i = 0; i < 12; i++) begin
      rd_req = 1'b1; addr = 32'h60 + 32'(i);
      smp(); if (!read_pause) acc++;
      nxt();
    end
    check("t5_fill", acc, 32'd8);
    smp(); check("t5_full_pause", 32'(read_pause), 32'd1);
    nxt(); rd_ready = 1'b1;
    smp(); check("t5_pop_pause", 32'(read_pause), 32'd1);
    nxt(); rd_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      addr = 32'h6C + 32'(i);
      smp(); if (!read_pause) acc++;
      nxt();
    end
    check("t5_one_more", acc, 32'd1);
    rd_req = 1'b0;
    drain();

    // enable drop with reads in flight and queued
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_req = 1'b1; addr = 32'h70 + 32'(i);
      smp(); check("t6_acc", 32'(read_pause), 32'd0);
      nxt();
    end
    rd_req = 1'b0; enable = 1'b0;
    smp(); nxt(); smp(); nxt(); smp();
    check("t6_flush_valid", 32'(rd_valid), 32'd0);
    check("t6_flush_rp", 32'(read_pause), 32'd1);
    check("t6_flush_wp", 32'(write_pause), 32'd1);
    exp_q.delete();
    nxt(); smp(); check("t6_idle_rp", 32'(read_pause), 32'd1);
    nxt(); enable = 1'b1;
    smp(); check("t6_idle_seen", 32'(read_pause), 32'd1);
    nxt(); smp();
    check("t6_reactive", 32'(read_pause), 32'd0);
    check("t6_no_stale", 32'(rd_valid), 32'd0);
    nxt(); rd_req = 1'b1; addr = 32'h10;
    smp(); check("t6_rd_acc", 32'(read_pause), 32'd0);
    nxt(); rd_req = 1'b0;
    drain();

    // Asynchronous reset mid-burst
    wr_req = 1'b1; addr = 32'h50; wr_data = 32'hBEEF;
    nxt(); wr_req = 1'b0; rd_req = 1'b1; addr = 32'h51;
    nxt(); addr = 32'h52;
    check("t1_pre_cs", 32'(ram_cs), 32'd1);
    reset = 1'b1; rd_req = 1'b0;
    #1;
    check("t1_cs", 32'(ram_cs), 32'd0);
    check("t1_we", 32'(ram_we), 32'd0);
    check("t1_addr", ram_addr, 32'd0);
    check("t1_wdata", ram_wdata, 32'd0);
    check("t1_valid", 32'(rd_valid), 32'd0);
    check("t1_rp", 32'(read_pause), 32'd1);
    check("t1_wp", 32'(write_pause), 32'd1);
    exp_q.delete();
    nxt(); nxt(); reset = 1'b0;
    smp(); check("t1_idle_rp", 32'(read_pause), 32'd1);
    nxt(); smp(); check("t1_active_rp", 32'(read_pause), 32'd0);

    // Round-robin under contention, starting from the post-reset state
    nxt();
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; wr_req = 1'b1; addr = 32'h30 + 32'(i); wr_data = 32'h5000 + 32'(i);
      smp();
      check("t4_rp", 32'(read_pause), 32'(i % 2));
      check("t4_wp", 32'(write_pause), 32'(1 - (i % 2)));
      nxt();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    nxt(); nxt();
    rd_req = 1'b1; addr = 32'h31;
    smp(); check("t4_rb_acc", 32'(read_pause), 32'd0);
    nxt(); rd_req = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
